instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction memory interface.
- Owns the PC and drives Instruction_Add (a word index; the memory is 32 words deep).
- Samples the returned Instruction into an IF/ID pipeline register and handles stall and branch redirect.
- Halts permanently when the memory raises Exit or the PC leaves the populated range. Sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 0: word index loaded into the PC on reset.
- MAX_ADDR, 31: highest valid word index. Any PC above it is treated as end of program.
- COUNT_WIDTH, 32: width of Fetch_Count.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  leaves IDLE and begins fetching.
- Stall  input  1  decode-stage hazard; freezes the PC and IF/ID.
- Branch_Taken  input  1  redirect request from a later stage.
- Branch_Target  input  32  word index to redirect to.
- Instruction  input  32  instruction word returned combinationally by the memory.
- Exit  input  1  memory end-of-program flag. Once set it stays high until the memory is reloaded.
- Instruction_Add  output  32  current PC, driven combinationally from the PC register.
- IF_ID_Instruction  output  32  latched instruction.
- IF_ID_PC  output  32  PC of the latched instruction.
- IF_ID_Valid  output  1  IF/ID holds a real instruction.
- Halted  output  1  unit is in HALT.
- Fetch_Count  output  COUNT_WIDTH  number of instructions delivered to IF/ID.

Behaviour:
- Reset (synchronous; highest priority, also mid-operation) sets the following on the next edge:
  - state=IDLE, PC=RESET_PC
  - IF_ID_Instruction=0, IF_ID_PC=0, IF_ID_Valid=0
  - Halted=0, Fetch_Count=0
- States: IDLE, RUN, HALT.
- IDLE:
  - PC held, IF_ID_Valid=0, Exit ignored.
  - Start=1 at an edge -> RUN. No fetch is captured on that edge.
- RUN: per-edge priority, highest first.
  1. Branch_Taken=1:
     - PC<=Branch_Target, IF_ID_Valid<=0, Fetch_Count unchanged.
     - Overrides Stall and Exit; the Exit seen at the wrong-path address is discarded.
     - State stays RUN.
  2. Stall=1: PC, IF/ID, Fetch_Count and state all held. Exit is not evaluated.
  3. Exit=1 or PC>MAX_ADDR:
     - state<=HALT, Halted<=1, IF_ID_Valid<=0.
     - PC held at the terminating address; Fetch_Count unchanged.
     - The Instruction value is not captured.
  4. Otherwise:
     - IF_ID_Instruction<=Instruction, IF_ID_PC<=PC, IF_ID_Valid<=1.
     - PC<=PC+1 (32-bit, wraps modulo 2^32).
     - Fetch_Count<=Fetch_Count+1 (wraps).
- HALT:
  - Terminal until Reset; Start, Stall and Branch_Taken are ignored.
  - Halted=1, IF_ID_Valid=0, PC frozen, Instruction_Add stable.
- Latency: an instruction at address A appears on IF_ID_* one edge after Instruction_Add=A, provided no stall occurs.
- Exit is a level and is not cleared by the memory, so the unit never re-evaluates it after halting.
- Instruction is sampled only in case 4. X values on Instruction in other cases have no effect.
- A redirect to Branch_Target>MAX_ADDR is accepted; the next RUN edge halts.
- Start while in RUN is ignored.

Test Plan:
- Reset, Start, memory loaded with words 0..3, Exit rising at address 4:
  - IF_ID_PC sequence is 0,1,2,3 with Valid=1.
  - Halted=1 at the edge after Instruction_Add=4; Fetch_Count=4; Instruction_Add stays 4.
- Stall held high for 3 cycles while PC=2:
  - Instruction_Add stays 2 and IF_ID_PC stays 1, with Valid unchanged.
  - Fetching resumes with IF_ID_PC=2 on the first unstalled edge.
- Branch_Taken=1, Branch_Target=10 while PC=5:
  - Next edge: Instruction_Add=10, IF_ID_Valid=0, Fetch_Count unchanged.
  - Following edge: IF_ID_PC=10.
- Branch_Taken=1 in the same cycle as Exit=1 at PC=7, target 3: no halt, Instruction_Add=3, Halted=0.
- No Exit in memory, MAX_ADDR=31: unit fetches 0..31 (Fetch_Count=32), then halts with Instruction_Add=32.
- Reset asserted in HALT and in RUN at PC=9:
  - All outputs return to reset values next edge; state IDLE.
  - Fetching restarts from 0 only after Start.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory word
// address, captures the returned word into the IF/ID register and handles
// stall, branch redirect and end-of-program halt.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | after reset; PC held, nothing fetched, waiting for Start
// S_RUN  | fetching one word per edge unless stalled or redirected
// S_HALT | end of program reached; frozen until Reset
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] MAX_ADDR    = 32'd31,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic                   i_Stall,
  input  logic                   i_Branch_Taken,
  input  logic [31:0]            i_Branch_Target,
  input  logic [31:0]            i_Instruction,
  input  logic                   i_Exit,
  output logic [31:0]            o_Instruction_Add,
  output logic [31:0]            o_IF_ID_Instruction,
  output logic [31:0]            o_IF_ID_PC,
  output logic                   o_IF_ID_Valid,
  output logic                   o_Halted,
  output logic [COUNT_WIDTH-1:0] o_Fetch_Count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t                 r_state;
  logic [31:0]            r_pc;
  logic [31:0]            r_if_id_instr;
  logic [31:0]            r_if_id_pc;
  logic                   r_if_id_valid;
  logic [COUNT_WIDTH-1:0] r_fetch_count;

  state_t                 w_state_nxt;
  logic [31:0]            w_pc_nxt;
  logic [31:0]            w_if_id_instr_nxt;
  logic [31:0]            w_if_id_pc_nxt;
  logic                   w_if_id_valid_nxt;
  logic [COUNT_WIDTH-1:0] w_fetch_count_nxt;
  logic                   w_end_of_prog;

  assign w_end_of_prog = i_Exit || (r_pc > MAX_ADDR);

  // Next-state and datapath decode; branch beats stall beats halt beats fetch.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_id_instr_nxt = r_if_id_instr;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_valid_nxt = r_if_id_valid;
    w_fetch_count_nxt = r_fetch_count;
    case (r_state)
      S_IDLE: begin
        w_if_id_valid_nxt = 1'b0;
        if (i_Start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (i_Branch_Taken) begin
          // Anything seen at the wrong-path address, Exit included, is dropped.
          w_pc_nxt          = i_Branch_Target;
          w_if_id_valid_nxt = 1'b0;
        end else if (i_Stall) begin
          w_state_nxt = S_RUN;
        end else if (w_end_of_prog) begin
          w_state_nxt       = S_HALT;
          w_if_id_valid_nxt = 1'b0;
        end else begin
          w_if_id_instr_nxt = i_Instruction;
          w_if_id_pc_nxt    = r_pc;
          w_if_id_valid_nxt = 1'b1;
          w_pc_nxt          = r_pc + 32'd1;
          w_fetch_count_nxt = r_fetch_count + COUNT_WIDTH'(1);
        end
      end
      S_HALT: begin
        w_if_id_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt       = S_IDLE;
        w_if_id_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_if_id_instr <= 32'd0;
      r_if_id_pc    <= 32'd0;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_id_instr <= w_if_id_instr_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  assign o_Instruction_Add   = r_pc;
  assign o_IF_ID_Instruction = r_if_id_instr;
  assign o_IF_ID_PC          = r_if_id_pc;
  assign o_IF_ID_Valid       = r_if_id_valid;
  assign o_Halted            = (r_state == S_HALT);
  assign o_Fetch_Count       = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 32-word memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, br;
  logic [31:0] target;
  logic [31:0] instr;
  logic        exit_w;
  logic [31:0] addr;
  logic [31:0] if_instr, if_pc;
  logic        if_valid, halted;
  logic [31:0] fcount;

  logic        exit_manual;
  logic        exit_auto;
  logic [31:0] exit_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd32) ? (32'hA500_0000 | a) : 32'hBAD0_0000;
  endfunction

  assign instr  = mem_word(addr);
  assign exit_w = exit_manual | (exit_auto && (addr >= exit_addr));

  instruction_fetch_unit dut (
    .i_Clock             (clk),
    .i_Reset             (rst),
    .i_Start             (start),
    .i_Stall             (stall),
    .i_Branch_Taken      (br),
    .i_Branch_Target     (target),
    .i_Instruction       (instr),
    .i_Exit              (exit_w),
    .o_Instruction_Add   (addr),
    .o_IF_ID_Instruction (if_instr),
    .o_IF_ID_PC          (if_pc),
    .o_IF_ID_Valid       (if_valid),
    .o_Halted            (halted),
    .o_Fetch_Count       (fcount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; br = 0; target = 0; exit_manual = 0; rst = 0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_add, input logic [31:0] e_pc,
                             input logic e_valid, input logic e_halt, input logic [31:0] e_cnt);
    chk({tag, ".add"},    addr,     e_add);
    chk({tag, ".ifpc"},   if_pc,    e_pc);
    chk({tag, ".valid"},  {31'd0, if_valid}, {31'd0, e_valid});
    chk({tag, ".halted"}, {31'd0, halted},   {31'd0, e_halt});
    chk({tag, ".count"},  fcount,   e_cnt);
    if (e_valid) chk({tag, ".instr"}, if_instr, mem_word(e_pc));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  typedef struct {
    logic        start, stall, br, ex;
    logic [31:0] target;
    logic [31:0] e_add, e_pc;
    logic        e_valid, e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    //        st  sl  br  ex  tgt    add   ifpc  v  h  cnt
    vecs[0]  = '{1, 0, 0, 0, 0,     0,    0,    0, 0, 0};   // start, no capture
    vecs[1]  = '{0, 0, 0, 0, 0,     1,    0,    1, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0,     2,    1,    1, 0, 2};
    vecs[3]  = '{0, 1, 0, 0, 0,     2,    1,    1, 0, 2};   // stall x3 at PC=2
    vecs[4]  = '{0, 1, 0, 0, 0,     2,    1,    1, 0, 2};
    vecs[5]  = '{0, 1, 0, 0, 0,     2,    1,    1, 0, 2};
    vecs[6]  = '{0, 0, 0, 0, 0,     3,    2,    1, 0, 3};
    vecs[7]  = '{0, 0, 0, 0, 0,     4,    3,    1, 0, 4};
    vecs[8]  = '{0, 0, 0, 0, 0,     5,    4,    1, 0, 5};
    vecs[9]  = '{0, 0, 1, 0, 10,    10,   4,    0, 0, 5};   // branch at PC=5
    vecs[10] = '{0, 0, 0, 0, 0,     11,   10,   1, 0, 6};
    vecs[11] = '{0, 0, 1, 0, 7,     7,    10,   0, 0, 6};
    vecs[12] = '{0, 0, 1, 1, 3,     3,    10,   0, 0, 6};   // branch beats exit at PC=7
    vecs[13] = '{0, 1, 0, 1, 0,     3,    10,   0, 0, 6};   // stall hides exit
    vecs[14] = '{1, 0, 0, 0, 0,     4,    3,    1, 0, 7};   // start in RUN ignored
    vecs[15] = '{0, 1, 1, 0, 40,    40,   3,    0, 0, 7};   // branch beats stall, out of range
    vecs[16] = '{0, 0, 0, 0, 0,     40,   3,    0, 1, 7};   // halts on out-of-range PC
    vecs[17] = '{1, 1, 1, 0, 0,     40,   3,    0, 1, 7};   // HALT ignores everything

    exit_auto = 0; exit_addr = 0;
    do_reset();
    check_state("reset", 0, 0, 0, 0, 0);
    chk("reset.instr", if_instr, 32'd0);

    for (int i = 0; i < 18; i++) begin
      start = vecs[i].start; stall = vecs[i].stall; br = vecs[i].br;
      exit_manual = vecs[i].ex; target = vecs[i].target;
      step();
      check_state($sformatf("vec%0d", i), vecs[i].e_add, vecs[i].e_pc,
                  vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_cnt);
    end

    // Exit rising at address 4.
    do_reset();
    exit_auto = 1; exit_addr = 4;
    start = 1; step(); start = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_state($sformatf("exit.f%0d", k), k + 1, k, 1, 0, k + 1);
    end
    step();
    check_state("exit.halt", 4, 3, 0, 1, 4);
    step();
    check_state("exit.hold", 4, 3, 0, 1, 4);
    exit_auto = 0;

    // Full range without Exit: fetch 0..31 then halt at 32.
    do_reset();
    start = 1; step(); start = 0;
    for (int k = 0; k < 32; k++) step();
    check_state("full.last", 32, 31, 1, 0, 32);
    step();
    check_state("full.halt", 32, 31, 0, 1, 32);

    // Reset while in HALT.
    rst = 1; step(); rst = 0;
    check_state("rsthalt", 0, 0, 0, 0, 0);
    chk("rsthalt.instr", if_instr, 32'd0);

    // Reset mid-run at PC=9, then restart only after Start.
    start = 1; step(); start = 0;
    for (int k = 0; k < 9; k++) step();
    check_state("run9", 9, 8, 1, 0, 9);
    rst = 1; step(); rst = 0;
    check_state("rstrun", 0, 0, 0, 0, 0);
    chk("rstrun.instr", if_instr, 32'd0);
    step(); step();
    check_state("idle.wait", 0, 0, 0, 0, 0);
    start = 1; step(); start = 0;
    check_state("restart", 0, 0, 0, 0, 0);
    step();
    check_state("restart.f0", 1, 0, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
